// File: rtl/pe_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pe_cmd_sequencer
//  Purpose  : Host-side sequencer for the shared serial command line that
//             feeds every PE controller. Commands {addr, op} are queued in a
//             small FIFO and sent one at a time as a frame:
//               start bit (0), addr[7:0] MSB first, op[2:0] MSB first,
//             then the line is held high for an opcode-dependent execute
//             window (none for NO_OP) plus a guard gap.
//  Ports    : clk, nRst        - clock, asynchronous active-low reset
//             cmd_valid/ready  - host command handshake (ready = FIFO not full)
//             cmd_addr/cmd_op  - command payload
//             flush            - synchronous clear of queued commands
//             tx               - serial command line, idle high, registered
//             busy             - registered, high while a frame is active
//             frame_done       - one-cycle pulse after a frame's full window
//             fifo_count       - number of queued commands
//  Revision : 1.0 - initial release
// ============================================================================
module pe_cmd_sequencer #(
    parameter int DEPTH       = 4,
    parameter int EXEC_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                     clk,
    input  logic                     nRst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [7:0]               cmd_addr,
    input  logic [2:0]               cmd_op,
    input  logic                     flush,
    output logic                     tx,
    output logic                     busy,
    output logic                     frame_done,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int LOAD_MAX = (EXEC_CYCLES > GAP_CYCLES) ? EXEC_CYCLES - 1 : GAP_CYCLES - 1;
    // The counter must hold both the bit index (up to 7) and the window loads.
    localparam int CNT_MAX  = (LOAD_MAX > 7) ? LOAD_MAX : 7;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] ADDR_LOAD  = CNT_W'(7);
    localparam logic [CNT_W-1:0] OP_LOAD    = CNT_W'(2);
    localparam logic [CNT_W-1:0] EXEC_LOAD  = CNT_W'(EXEC_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [2:0]       OP_NO_OP   = 3'h7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_ADDR  = 3'd2,
        S_OP    = 3'd3,
        S_EXEC  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [10:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             push_w;
    logic             pop_w;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [7:0]       addr_q,  addr_d;
    logic [2:0]       op_q,    op_d;
    logic             tx_q,    tx_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [2:0]       bit_sel_w;

    // Ready depends only on the count, so a full FIFO refuses a push even
    // when a pop happens on the same edge.
    assign cmd_ready  = (count_q != FULL_COUNT);
    assign push_w     = cmd_valid & cmd_ready & ~flush;
    assign pop_w      = (state_q == S_IDLE) & (count_q != '0) & ~flush;

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign fifo_count = count_q;

    // Bit index of the next bit to drive while counting down a field.
    assign bit_sel_w  = 3'(cnt_q[2:0] - 3'd1);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_w) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop_w) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push_w, pop_w})
                2'b10:   count_d = count_q + COUNT_ONE;
                2'b01:   count_d = count_q - COUNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_w) begin
            mem_q[wr_ptr_q] <= {cmd_addr, cmd_op};
        end
    end

    // Each state computes the line value for the following cycle so that tx
    // comes straight from a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        op_d    = op_q;
        tx_d    = 1'b1;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop_w) begin
                    {addr_d, op_d} = mem_q[rd_ptr_q];
                    tx_d           = 1'b0;
                    state_d        = S_START;
                end
            end
            S_START: begin
                tx_d    = addr_q[7];
                cnt_d   = ADDR_LOAD;
                state_d = S_ADDR;
            end
            S_ADDR: begin
                if (cnt_q == '0) begin
                    tx_d    = op_q[2];
                    cnt_d   = OP_LOAD;
                    state_d = S_OP;
                end else begin
                    tx_d    = addr_q[bit_sel_w];
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            S_OP: begin
                if (cnt_q == '0) begin
                    // NO_OP leaves the PEs nothing to execute, skip the window.
                    if (op_q == OP_NO_OP) begin
                        cnt_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end else begin
                        cnt_d   = EXEC_LOAD;
                        state_d = S_EXEC;
                    end
                end else begin
                    tx_d  = op_q[bit_sel_w[1:0]];
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    cnt_d   = GAP_LOAD;
                    state_d = S_GAP;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            op_q     <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            op_q     <= op_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pe_cmd_sequencer
//  Purpose  : Directed self-checking bench for pe_cmd_sequencer with default
//             parameters. Inputs change on the falling edge, outputs are
//             observed on the falling edge. A line monitor decodes frames
//             and records start-bit and frame_done cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pe_cmd_sequencer;

    localparam int DEPTH       = 4;
    localparam int EXEC_CYCLES = 4;
    localparam int GAP_CYCLES  = 2;

    logic       clk       = 1'b0;
    logic       nRst      = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_addr  = 8'h00;
    logic [2:0] cmd_op    = 3'h0;
    logic       flush     = 1'b0;
    logic       cmd_ready;
    logic       tx;
    logic       busy;
    logic       frame_done;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pe_cmd_sequencer #(
        .DEPTH       (DEPTH),
        .EXEC_CYCLES (EXEC_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES)
    ) dut (
        .clk        (clk),
        .nRst       (nRst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_op     (cmd_op),
        .flush      (flush),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done),
        .fifo_count (fifo_count)
    );

    // ------------------------------------------------------------------
    // Line monitor
    // ------------------------------------------------------------------
    int          cyc     = 0;
    logic        prev_tx = 1'b1;
    int          rx_cnt  = 0;
    logic [10:0] rx_sh   = '0;
    logic [10:0] rx_q[$];
    int          start_q[$];
    int          done_q[$];

    always @(negedge clk) begin
        cyc++;
        if (!nRst) begin
            rx_cnt  = 0;
            prev_tx = 1'b1;
        end else begin
            if (rx_cnt == 0) begin
                if (prev_tx && !tx) begin
                    rx_cnt = 1;
                    start_q.push_back(cyc);
                end
            end else begin
                rx_sh = {rx_sh[9:0], tx};
                if (rx_cnt == 11) begin
                    rx_q.push_back(rx_sh);
                    rx_cnt = 0;
                end else begin
                    rx_cnt++;
                end
            end
            if (frame_done) done_q.push_back(cyc);
            prev_tx = tx;
        end
    end

    // Expected {tx, busy, frame_done} k cycles after the start bit appears.
    function automatic logic [2:0] exp_sig(input logic [7:0] a, input logic [2:0] o, input int k);
        int   len;
        logic t;
        len = (o == 3'h7) ? 12 + GAP_CYCLES : 12 + EXEC_CYCLES + GAP_CYCLES;
        if (k == 0)       t = 1'b0;
        else if (k <= 8)  t = a[8 - k];
        else if (k <= 11) t = o[11 - k];
        else              t = 1'b1;
        return {t, (k < len), (k == len)};
    endfunction

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (!(!busy && fifo_count == 3'd0 && tx && !frame_done) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL wait_idle: timeout after %0d cycles, busy=%b count=%0d", n, busy, fifo_count);
        end
    endtask

    task automatic clear_mon();
        rx_q.delete();
        start_q.delete();
        done_q.delete();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        nRst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({tx, busy, frame_done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_outputs: got tx/busy/done=%b expected 100", {tx, busy, frame_done});
        end
        checks++;
        if (fifo_count !== 3'd0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_fifo: got count=%0d ready=%b expected 0/1", fifo_count, cmd_ready);
        end
        nRst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({tx, busy, frame_done} !== 3'b100 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_idle: got tx/busy/done=%b count=%0d expected 100/0", {tx, busy, frame_done}, fifo_count);
        end
    endtask

    task automatic run_single(input string name, input logic [7:0] a, input logic [2:0] o, input int n);
        logic [2:0] got;
        cmd_valid = 1'b1; cmd_addr = a; cmd_op = o;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd1 || tx !== 1'b1) begin
            errors++;
            $display("FAIL %s_accept: got count=%0d tx=%b expected 1/1", name, fifo_count, tx);
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            got = {tx, busy, frame_done};
            checks++;
            if (got !== exp_sig(a, o, k)) begin
                errors++;
                $display("FAIL %s_cycle%0d: got tx/busy/done=%b expected %b", name, k, got, exp_sig(a, o, k));
            end
        end
    endtask

    task automatic test_single();
        wait_idle(50);
        run_single("single_mul", 8'hA5, 3'h5, 20);
    endtask

    task automatic test_noop();
        wait_idle(50);
        run_single("noop", 8'h3C, 3'h7, 16);
    endtask

    task automatic test_back_to_back();
        logic [10:0] cmds [5];
        cmds = '{{8'h11, 3'h0}, {8'h22, 3'h1}, {8'h33, 3'h2}, {8'h44, 3'h3}, {8'h55, 3'h6}};
        wait_idle(50);
        clear_mon();
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            {cmd_addr, cmd_op} = cmds[i];
            @(negedge clk);
        end
        checks++;
        if (fifo_count !== 3'd4 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full: got count=%0d ready=%b expected 4/0", fifo_count, cmd_ready);
        end
        // Extra command offered while full must be refused.
        {cmd_addr, cmd_op} = {8'hFF, 3'h0};
        @(negedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL b2b_reject: got count=%0d expected 4", fifo_count);
        end
        wait_idle(200);
        checks++;
        if (rx_q.size() != 5 || start_q.size() != 5) begin
            errors++;
            $display("FAIL b2b_frames: got %0d frames %0d starts expected 5", rx_q.size(), start_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (rx_q[i] !== cmds[i]) begin
                    errors++;
                    $display("FAIL b2b_data%0d: got %h expected %h", i, rx_q[i], cmds[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (start_q[i] - start_q[i-1] != 19) begin
                        errors++;
                        $display("FAIL b2b_spacing%0d: got %0d expected 19", i, start_q[i] - start_q[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_flush();
        logic [10:0] cmds [4];
        int lows;
        cmds = '{{8'h5A, 3'h1}, {8'h66, 3'h2}, {8'h77, 3'h3}, {8'h88, 3'h4}};
        wait_idle(50);
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1;
            {cmd_addr, cmd_op} = cmds[i];
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd3) begin
            errors++;
            $display("FAIL flush_queued: got count=%0d expected 3", fifo_count);
        end
        repeat (3) @(negedge clk);
        flush = 1'b1; cmd_valid = 1'b1; {cmd_addr, cmd_op} = {8'h99, 3'h5};
        @(negedge clk);
        flush = 1'b0; cmd_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: got count=%0d busy=%b expected 0/1", fifo_count, busy);
        end
        wait_idle(50);
        lows = 0;
        repeat (25) begin
            @(negedge clk);
            if (!tx) lows++;
        end
        checks++;
        if (lows != 0) begin
            errors++;
            $display("FAIL flush_line_idle: got %0d low cycles expected 0", lows);
        end
        checks++;
        if (rx_q.size() != 1 || start_q.size() != 1 || done_q.size() != 1) begin
            errors++;
            $display("FAIL flush_frames: got %0d frames %0d done expected 1", rx_q.size(), done_q.size());
        end else begin
            checks++;
            if (rx_q[0] !== cmds[0] || done_q[0] - start_q[0] != 18) begin
                errors++;
                $display("FAIL flush_inflight: got %h done_after=%0d expected %h/18", rx_q[0], done_q[0] - start_q[0], cmds[0]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        wait_idle(50);
        cmd_valid = 1'b1; {cmd_addr, cmd_op} = {8'h81, 3'h3};
        @(negedge clk);
        {cmd_addr, cmd_op} = {8'h42, 3'h4};
        @(negedge clk);
        cmd_valid = 1'b0;
        // Now at the start bit; addr[3] of 8'h81 is a 0 five cycles later.
        repeat (5) @(negedge clk);
        checks++;
        if (tx !== 1'b0 || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL rst_pre: got tx=%b count=%0d expected 0/1", tx, fifo_count);
        end
        nRst = 1'b0;
        #1;
        checks++;
        if ({tx, busy, frame_done} !== 3'b100 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL rst_async: got tx/busy/done=%b count=%0d expected 100/0", {tx, busy, frame_done}, fifo_count);
        end
        @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);
        run_single("rst_after", 8'hC3, 3'h2, 20);
    endtask

    task automatic test_push_pop_wrap();
        logic [10:0] cmds [10];
        int idx;
        int n;
        for (int i = 0; i < 10; i++) cmds[i] = {8'(8'h10 + i * 17), 3'(i % 8)};
        wait_idle(50);
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1;
            {cmd_addr, cmd_op} = cmds[i];
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        n = 0;
        while (!frame_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!frame_done || fifo_count !== 3'd2) begin
            errors++;
            $display("FAIL pp_before: got done=%b count=%0d expected 1/2", frame_done, fifo_count);
        end
        // Push lands on the same edge as the IDLE pop.
        cmd_valid = 1'b1; {cmd_addr, cmd_op} = cmds[3];
        @(negedge clk);
        checks++;
        if (fifo_count !== 3'd2 || tx !== 1'b0) begin
            errors++;
            $display("FAIL pp_same_edge: got count=%0d tx=%b expected 2/0", fifo_count, tx);
        end
        idx = 4;
        n = 0;
        while (idx < 10 && n < 400) begin
            if (cmd_ready) begin
                cmd_valid = 1'b1;
                {cmd_addr, cmd_op} = cmds[idx];
                idx++;
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b0;
        wait_idle(300);
        checks++;
        if (rx_q.size() != 10) begin
            errors++;
            $display("FAIL pp_frames: got %0d frames expected 10", rx_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (rx_q[i] !== cmds[i]) begin
                    errors++;
                    $display("FAIL pp_data%0d: got %h expected %h", i, rx_q[i], cmds[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_noop();
        test_back_to_back();
        test_flush();
        test_reset_midframe();
        test_push_pop_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
